reg_desplazamiento_universal: RTL and testbench

Parametrised universal register that generalises the single-bit D flip-flop to WIDTH bits.
Modes are hold, shift right, shift left and parallel load, with serial inputs and outputs at both ends.
A shift counter flags when a full word has been shifted, so the block can act as serializer or deserializer for later sequential exercises.

---
 rtl/reg_desplazamiento_pkg.sv | 17 +
 rtl/reg_desplazamiento_universal_contador.sv | 37 +++
 rtl/reg_desplazamiento_universal.sv | 79 +++++++
 tb/tb_reg_desplazamiento_universal.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/reg_desplazamiento_pkg.sv
// Shared definitions for the universal shift register family.
package reg_desplazamiento_pkg;

  // Operating modes selected by the 2-bit mode input
  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

  // True for the two modes that move data by one bit position
  function automatic logic is_shift(input mode_t m);
    return (m == MODE_SHR) || (m == MODE_SHL);
  endfunction

endpackage

// File: rtl/reg_desplazamiento_universal_contador.sv
// Shift counter: counts shifts within a word and pulses done on the WIDTH-th one.
module contador_desplazamientos #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  input  logic          restart,
  output logic [CW-1:0] shift_count,
  output logic          done
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Count shifts, wrap at the end of a word and flag it for one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_count <= '0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clr || restart) begin
        shift_count <= '0;
      end else if (inc) begin
        if (shift_count == LAST) begin
          shift_count <= '0;
          done        <= 1'b1;
        end else begin
          shift_count <= shift_count + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/reg_desplazamiento_universal.sv
// Universal WIDTH-bit register: hold, shift right, shift left, parallel load.
module reg_desplazamiento_universal
  import reg_desplazamiento_pkg::*;
#(
  parameter int unsigned       WIDTH       = 8,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
  localparam int unsigned      CW          = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_msb,
  input  logic             sin_lsb,
  output logic [WIDTH-1:0] q,
  output logic             sout_lsb,
  output logic             sout_msb,
  output logic [CW-1:0]    shift_count,
  output logic             done
);

  mode_t            mode_sel;
  logic [WIDTH-1:0] shr_value;
  logic [WIDTH-1:0] shl_value;
  logic             inc;
  logic             restart;

  assign mode_sel = mode_t'(mode);

  // A 1-bit register has no neighbouring bits: each shift just takes the serial input
  generate
    if (WIDTH == 1) begin : g_single
      assign shr_value = {sin_msb};
      assign shl_value = {sin_lsb};
    end else begin : g_multi
      assign shr_value = {sin_msb, q[WIDTH-1:1]};
      assign shl_value = {q[WIDTH-2:0], sin_lsb};
    end
  endgenerate

  // Data register with priority clr > en > mode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_VALUE;
    end else if (clr) begin
      q <= RESET_VALUE;
    end else if (en) begin
      case (mode_sel)
        MODE_HOLD: q <= q;
        MODE_SHR:  q <= shr_value;
        MODE_SHL:  q <= shl_value;
        MODE_LOAD: q <= d;
        default:   q <= q;
      endcase
    end
  end

  assign inc     = en && is_shift(mode_sel);
  assign restart = en && (mode_sel == MODE_LOAD);

  contador_desplazamientos #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_contador (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr),
    .inc         (inc),
    .restart     (restart),
    .shift_count (shift_count),
    .done        (done)
  );

  assign sout_lsb = q[0];
  assign sout_msb = q[WIDTH-1];

endmodule

// File: tb/tb_reg_desplazamiento_universal.sv
// Directed bench for reg_desplazamiento_universal with WIDTH=8.
module tb_reg_desplazamiento_universal;
  import reg_desplazamiento_pkg::*;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic         clr = 1'b0;
  logic [1:0]   mode = MODE_HOLD;
  logic [W-1:0] d = '0;
  logic         sin_msb = 1'b0;
  logic         sin_lsb = 1'b0;
  logic [W-1:0] q;
  logic         sout_lsb;
  logic         sout_msb;
  logic [2:0]   shift_count;
  logic         done;

  int passed = 0;
  int total  = 0;

  reg_desplazamiento_universal #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .d(d),
    .sin_msb(sin_msb), .sin_lsb(sin_lsb), .q(q), .sout_lsb(sout_lsb),
    .sout_msb(sout_msb), .shift_count(shift_count), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic       en;
    logic [1:0] mode;
    logic [7:0] d;
    logic       sm;
    logic       sl;
    logic [7:0] eq;
    logic [2:0] ecnt;
    logic       edone;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic c, input logic e, input logic [1:0] m,
                              input logic [7:0] dd, input logic sm, input logic sl,
                              input logic [7:0] eq, input logic [2:0] ec, input logic ed);
    vec_t v;
    v.clr = c; v.en = e; v.mode = m; v.d = dd; v.sm = sm; v.sl = sl;
    v.eq = eq; v.ecnt = ec; v.edone = ed;
    return v;
  endfunction

  task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s #%0d: got %0h, expected %0h", nm, idx, act, exp);
    else
      passed++;
  endtask

  task automatic check_all(input string tag, input int idx, input logic [7:0] eq,
                           input logic [2:0] ec, input logic ed);
    check({tag, ".q"}, idx, 32'(q), 32'(eq));
    check({tag, ".count"}, idx, 32'(shift_count), 32'(ec));
    check({tag, ".done"}, idx, 32'(done), 32'(ed));
    check({tag, ".sout_lsb"}, idx, 32'(sout_lsb), 32'(eq[0]));
    check({tag, ".sout_msb"}, idx, 32'(sout_msb), 32'(eq[7]));
  endtask

  initial begin
    logic [7:0] qm;
    logic [2:0] cm;
    logic [7:0] shl_bits;

    // Load A5, shift right 8 with sin_msb=0
    vecs.push_back(mk(0, 1, MODE_LOAD, 8'hA5, 0, 0, 8'hA5, 0, 0));
    vecs.push_back(mk(0, 1, MODE_SHR, 8'h00, 0, 0, 8'h52, 1, 0));
    vecs.push_back(mk(0, 1, MODE_SHR, 8'h00, 0, 0, 8'h29, 2, 0));
    vecs.push_back(mk(0, 1, MODE_SHR, 8'h00, 0, 0, 8'h14, 3, 0));
    vecs.push_back(mk(0, 1, MODE_SHR, 8'h00, 0, 0, 8'h0A, 4, 0));
    vecs.push_back(mk(0, 1, MODE_SHR, 8'h00, 0, 0, 8'h05, 5, 0));
    vecs.push_back(mk(0, 1, MODE_SHR, 8'h00, 0, 0, 8'h02, 6, 0));
    vecs.push_back(mk(0, 1, MODE_SHR, 8'h00, 0, 0, 8'h01, 7, 0));
    vecs.push_back(mk(0, 1, MODE_SHR, 8'h00, 0, 0, 8'h00, 0, 1));
    vecs.push_back(mk(0, 1, MODE_HOLD, 8'h00, 0, 0, 8'h00, 0, 0));
    // Load 00, shift left 8 with sin_lsb 1,1,0,0,1,0,1,1
    vecs.push_back(mk(0, 1, MODE_LOAD, 8'h00, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 1, MODE_SHL, 8'h00, 0, 1, 8'h01, 1, 0));
    vecs.push_back(mk(0, 1, MODE_SHL, 8'h00, 0, 1, 8'h03, 2, 0));
    vecs.push_back(mk(0, 1, MODE_SHL, 8'h00, 0, 0, 8'h06, 3, 0));
    vecs.push_back(mk(0, 1, MODE_SHL, 8'h00, 0, 0, 8'h0C, 4, 0));
    vecs.push_back(mk(0, 1, MODE_SHL, 8'h00, 0, 1, 8'h19, 5, 0));
    vecs.push_back(mk(0, 1, MODE_SHL, 8'h00, 0, 0, 8'h32, 6, 0));
    vecs.push_back(mk(0, 1, MODE_SHL, 8'h00, 0, 1, 8'h65, 7, 0));
    vecs.push_back(mk(0, 1, MODE_SHL, 8'h00, 0, 1, 8'hCB, 0, 1));
    vecs.push_back(mk(0, 1, MODE_HOLD, 8'h00, 0, 0, 8'hCB, 0, 0));
    // Load 81, 3 shifts, 2x en=0, 1 hold, 5 shifts
    vecs.push_back(mk(0, 1, MODE_LOAD, 8'h81, 0, 0, 8'h81, 0, 0));
    vecs.push_back(mk(0, 1, MODE_SHR, 8'h00, 0, 0, 8'h40, 1, 0));
    vecs.push_back(mk(0, 1, MODE_SHR, 8'h00, 0, 0, 8'h20, 2, 0));
    vecs.push_back(mk(0, 1, MODE_SHR, 8'h00, 0, 0, 8'h10, 3, 0));
    vecs.push_back(mk(0, 0, MODE_SHR, 8'h00, 1, 1, 8'h10, 3, 0));
    vecs.push_back(mk(0, 0, MODE_LOAD, 8'hFF, 1, 1, 8'h10, 3, 0));
    vecs.push_back(mk(0, 1, MODE_HOLD, 8'hFF, 1, 1, 8'h10, 3, 0));
    vecs.push_back(mk(0, 1, MODE_SHR, 8'h00, 0, 0, 8'h08, 4, 0));
    vecs.push_back(mk(0, 1, MODE_SHR, 8'h00, 0, 0, 8'h04, 5, 0));
    vecs.push_back(mk(0, 1, MODE_SHR, 8'h00, 0, 0, 8'h02, 6, 0));
    vecs.push_back(mk(0, 1, MODE_SHR, 8'h00, 0, 0, 8'h01, 7, 0));
    vecs.push_back(mk(0, 1, MODE_SHR, 8'h00, 0, 0, 8'h00, 0, 1));
    // Seven shifts then clr on the completing edge, then load on the completing edge
    for (int r = 0; r < 2; r++) begin
      vecs.push_back(mk(0, 1, MODE_LOAD, 8'hFF, 0, 0, 8'hFF, 0, 0));
      vecs.push_back(mk(0, 1, MODE_SHR, 8'h00, 0, 0, 8'h7F, 1, 0));
      vecs.push_back(mk(0, 1, MODE_SHR, 8'h00, 0, 0, 8'h3F, 2, 0));
      vecs.push_back(mk(0, 1, MODE_SHR, 8'h00, 0, 0, 8'h1F, 3, 0));
      vecs.push_back(mk(0, 1, MODE_SHR, 8'h00, 0, 0, 8'h0F, 4, 0));
      vecs.push_back(mk(0, 1, MODE_SHR, 8'h00, 0, 0, 8'h07, 5, 0));
      vecs.push_back(mk(0, 1, MODE_SHR, 8'h00, 0, 0, 8'h03, 6, 0));
      vecs.push_back(mk(0, 1, MODE_SHR, 8'h00, 0, 0, 8'h01, 7, 0));
      if (r == 0) begin
        vecs.push_back(mk(1, 1, MODE_SHR, 8'h00, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 1, MODE_HOLD, 8'h00, 0, 0, 8'h00, 0, 0));
      end else begin
        vecs.push_back(mk(0, 1, MODE_LOAD, 8'h3C, 0, 0, 8'h3C, 0, 0));
        vecs.push_back(mk(0, 1, MODE_HOLD, 8'h00, 0, 0, 8'h3C, 0, 0));
      end
    end

    // Asynchronous reset mid-cycle, checked before any clock edge
    #3 rst = 1'b1;
    #1 check_all("reset", 0, 8'h00, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      clr = vecs[i].clr; en = vecs[i].en; mode = vecs[i].mode; d = vecs[i].d;
      sin_msb = vecs[i].sm; sin_lsb = vecs[i].sl;
      @(posedge clk); #1;
      check_all("vec", i, vecs[i].eq, vecs[i].ecnt, vecs[i].edone);
    end

    // 24 back-to-back right shifts: done after every 8th, count wraps 0..7
    clr = 1'b0; en = 1'b1; mode = MODE_LOAD; d = 8'h00;
    @(posedge clk); #1;
    check_all("stream_load", 0, 8'h00, 0, 0);
    qm = 8'h00;
    mode = MODE_SHR;
    for (int k = 1; k <= 24; k++) begin
      sin_msb = logic'(k % 3 == 0);
      qm = {sin_msb, qm[7:1]};
      @(posedge clk); #1;
      check_all("stream", k, qm, 3'(k % 8), logic'(k % 8 == 0));
    end

    // Reset in the middle of a word discards the partial count
    shl_bits = 8'b1101_0011;
    mode = MODE_SHL;
    for (int k = 0; k < 3; k++) begin
      sin_lsb = shl_bits[k];
      @(posedge clk); #1;
    end
    check("midrst_pre.count", 0, 32'(shift_count), 32'd3);
    #1 rst = 1'b1;
    #1 check_all("midrst", 0, 8'h00, 0, 0);
    #1 rst = 1'b0;
    qm = 8'h00;
    cm = 3'd0;
    mode = MODE_SHR;
    sin_msb = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      qm = {1'b1, qm[7:1]};
      cm = cm + 3'd1;
      @(posedge clk); #1;
      check_all("after_rst", k, qm, cm, logic'(k == 8));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
